// File: rtl/raster_timing_gen.sv
// -----------------------------------------------------------------------------
// raster_timing_gen
//
// Purpose:
//   Raster timing generator feeding the sprite/overlay pipeline. Walks the
//   pixel raster one position per i_pix_en strobe and emits the coordinates
//   together with horizontal/vertical sync, active-video enable and a
//   frame-start pulse. Every output is a register and all of them describe the
//   same raster position. There is no skew between the coordinates and the
//   decoded signals.
//
// Ports:
//   i_clk          in   1   system clock, rising edge
//   i_rst_n        in   1   synchronous reset, active-low
//   i_pix_en       in   1   pixel advance strobe (tie high for pixel-rate clk)
//   o_x            out  16  horizontal position, 0..H_TOTAL-1
//   o_y            out  16  vertical position, 0..V_TOTAL-1
//   o_h_sync       out  1   horizontal sync, asserted level = HS_POL
//   o_v_sync       out  1   vertical sync, asserted level = VS_POL
//   o_de           out  1   active video (o_x < H_ACTIVE and o_y < V_ACTIVE)
//   o_frame_start  out  1   one-clock pulse when the position becomes (0,0)
//   o_frame_cnt    out  16  frames started since reset (optional, see below)
//
// Optional feature:
//   Define RASTER_TIMING_FRAME_CNT_EN to add o_frame_cnt. The counter
//   increments on the same edge that raises o_frame_start and wraps at 65535.
// -----------------------------------------------------------------------------
module raster_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_de,
    output logic        o_frame_start
`ifdef RASTER_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Elaboration-time sanity checks on the timing parameters.
    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
        $error("raster_timing_gen: H_ACTIVE and V_ACTIVE must be >= 1");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h_timing
        $error("raster_timing_gen: horizontal porch/sync values must be >= 1");
    end
    if (V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v_timing
        $error("raster_timing_gen: vertical porch/sync values must be >= 1");
    end
    if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_total
        $error("raster_timing_gen: H_TOTAL and V_TOTAL must fit in 16 bits");
    end

    // 16-bit views of the decode boundaries so every compare is width-matched.
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_STOP  = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_STOP  = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] x_next;
    logic [15:0] y_next;
    logic        end_of_line;
    logic        end_of_frame;
    logic        de_next;
    logic        hs_active_next;
    logic        vs_active_next;

    // The registered coordinates are the raster state. Everything else is
    // decoded from the *next* position so that it lands on the same edge as
    // the coordinates it describes.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        x_next         = o_x;
        y_next         = o_y;
        end_of_line    = (o_x == H_LAST);
        end_of_frame   = end_of_line && (o_y == V_LAST);

        if (end_of_line) begin
            x_next = '0;
            y_next = (o_y == V_LAST) ? '0 : o_y + 16'd1;
        end else begin
            x_next = o_x + 16'd1;
        end

        de_next        = (x_next < H_ACT) && (y_next < V_ACT);
        hs_active_next = (x_next >= HS_START) && (x_next < HS_STOP);
        // Decoded from y alone, so v_sync is held across the x=0 wrap edge and
        // produces exactly one rising and one falling edge per frame.
        vs_active_next = (y_next >= VS_START) && (y_next < VS_STOP);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all
    // outputs update together on the edge without ordering races.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_x           <= H_LAST;
            o_y           <= V_LAST;
            o_de          <= 1'b0;
            o_h_sync      <= ~HS_POL;
            o_v_sync      <= ~VS_POL;
            o_frame_start <= 1'b0;
        end else if (i_pix_en) begin
            o_x           <= x_next;
            o_y           <= y_next;
            o_de          <= de_next;
            o_h_sync      <= hs_active_next ? HS_POL : ~HS_POL;
            o_v_sync      <= vs_active_next ? VS_POL : ~VS_POL;
            o_frame_start <= end_of_frame;
        end else begin
            // Position holds between strobes. The frame pulse is one i_clk
            // wide, not one pixel wide.
            o_frame_start <= 1'b0;
        end
    end

`ifdef RASTER_TIMING_FRAME_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_frame_cnt <= '0;
        end else if (i_pix_en && end_of_frame) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_raster_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_raster_timing_gen
//
// Purpose:
//   Self-checking bench for raster_timing_gen. dut_a uses the default 640x480
//   timing and covers the reset/start vectors, full line timing, strobed
//   advance and mid-line reset. dut_b uses a small raster (15x11,
//   active-high syncs) so that several whole frames fit into a short run.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_raster_timing_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, pix_a, rst_n_b, pix_b;
    logic [15:0] x_a, y_a, x_b, y_b;
    logic        hs_a, vs_a, de_a, fs_a;
    logic        hs_b, vs_b, de_b, fs_b;
`ifdef RASTER_TIMING_FRAME_CNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    raster_timing_gen dut_a (
        .i_clk         (clk),
        .i_rst_n       (rst_n_a),
        .i_pix_en      (pix_a),
        .o_x           (x_a),
        .o_y           (y_a),
        .o_h_sync      (hs_a),
        .o_v_sync      (vs_a),
        .o_de          (de_a),
        .o_frame_start (fs_a)
`ifdef RASTER_TIMING_FRAME_CNT_EN
        ,
        .o_frame_cnt   (cnt_a)
`endif
    );

    // Small raster: H = 8+2+3+2 = 15, V = 6+1+2+2 = 11, frame = 165 strobes.
    // h_sync high at x 10..12, v_sync high at y 7..8.
    raster_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .HS_POL   (1'b1), .VS_POL (1'b1)
    ) dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_n_b),
        .i_pix_en      (pix_b),
        .o_x           (x_b),
        .o_y           (y_b),
        .o_h_sync      (hs_b),
        .o_v_sync      (vs_b),
        .o_de          (de_b),
        .o_frame_start (fs_b)
`ifdef RASTER_TIMING_FRAME_CNT_EN
        ,
        .o_frame_cnt   (cnt_b)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst_n;
        logic pix_en;
        int   ex;
        int   ey;
        logic ede;
        logic ehs;
        logic evs;
        logic efs;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int mx, my, err;
        int hs_low, hs_first_low, hs_rise;
        logic prev_hs, prev_vs, prev_fs;
        int fs_n, t1, t2, t3, vs_hi, hs_hi, rises, falls, ymax, wide;
        logic e_de, e_hs, e_vs, e_fs;

        rst_n_a = 1'b0; pix_a = 1'b0;
        rst_n_b = 1'b0; pix_b = 1'b0;

        // {rst_n, pix_en, x, y, de, h_sync, v_sync, frame_start} for dut_a.
        vecs[0] = '{1'b0, 1'b1, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0}; // reset beats pix_en
        vecs[1] = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0}; // released, no strobe
        vecs[2] = '{1'b1, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1}; // first strobe -> (0,0)
        vecs[3] = '{1'b1, 1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0}; // pulse is one clock
        vecs[4] = '{1'b1, 1'b0,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0}; // hold
        vecs[5] = '{1'b1, 1'b1,   2,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0}; // reset without strobe
        vecs[7] = '{1'b1, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b0}; // pulse drops on hold

        for (int i = 0; i < 9; i++) begin
            rst_n_a = vecs[i].rst_n;
            pix_a   = vecs[i].pix_en;
            step();
            check($sformatf("vec%0d_x", i),  32'(x_a),  32'(vecs[i].ex));
            check($sformatf("vec%0d_y", i),  32'(y_a),  32'(vecs[i].ey));
            check($sformatf("vec%0d_de", i), 32'(de_a), 32'(vecs[i].ede));
            check($sformatf("vec%0d_hs", i), 32'(hs_a), 32'(vecs[i].ehs));
            check($sformatf("vec%0d_vs", i), 32'(vs_a), 32'(vecs[i].evs));
            check($sformatf("vec%0d_fs", i), 32'(fs_a), 32'(vecs[i].efs));
        end

        // ---- dut_a: one full line from (0,0) at one strobe per clock ----
        mx = 0; my = 0; err = 0;
        hs_low = 0; hs_first_low = -1; hs_rise = -1; prev_hs = 1'b1;
        pix_a = 1'b1;
        for (int s = 0; s < 800; s++) begin
            if (mx == 799) begin mx = 0; my = my + 1; end else mx = mx + 1;
            step();
            e_de = (mx < 640) && (my < 480);
            e_hs = !((mx >= 656) && (mx < 752));
            if (32'(x_a) != mx || 32'(y_a) != my) err++;
            if (de_a !== e_de || hs_a !== e_hs || vs_a !== 1'b1 || fs_a !== 1'b0) err++;
            if (mx == 639) check("de_at_x639", 32'(de_a), 32'd1);
            if (mx == 640) check("de_at_x640", 32'(de_a), 32'd0);
            if (hs_a == 1'b0) begin
                hs_low++;
                if (hs_first_low < 0) hs_first_low = int'(x_a);
            end
            if (prev_hs == 1'b0 && hs_a == 1'b1 && hs_rise < 0) hs_rise = int'(x_a);
            prev_hs = hs_a;
        end
        check("line_model_errors", 32'(err), 32'd0);
        check("hsync_low_clocks", 32'(hs_low), 32'd96);
        check("hsync_first_low_x", 32'(hs_first_low), 32'd656);
        check("hsync_rise_x", 32'(hs_rise), 32'd752);
        check("line_wrap_x", 32'(x_a), 32'd0);
        check("line_wrap_y", 32'(y_a), 32'd1);

        // ---- dut_a: strobe every 4th clock ----
        err = 0;
        for (int c = 0; c < 40; c++) begin
            pix_a = (c % 4 == 0);
            if (pix_a) mx = mx + 1;
            step();
            if (32'(x_a) != mx || 32'(y_a) != 1 || fs_a !== 1'b0 || de_a !== 1'b1) err++;
        end
        check("strobe4_errors", 32'(err), 32'd0);
        check("strobe4_final_x", 32'(x_a), 32'd10);

        // ---- dut_a: reset in the middle of a visible line ----
        pix_a = 1'b1;
        for (int s = 0; s < 290; s++) step();
        check("midline_pre_x", 32'(x_a), 32'd300);
        check("midline_pre_de", 32'(de_a), 32'd1);
        rst_n_a = 1'b0;
        step();
        check("midline_rst_x", 32'(x_a), 32'd799);
        check("midline_rst_y", 32'(y_a), 32'd524);
        check("midline_rst_de", 32'(de_a), 32'd0);
        check("midline_rst_hs", 32'(hs_a), 32'd1);
        check("midline_rst_vs", 32'(vs_a), 32'd1);
        check("midline_rst_fs", 32'(fs_a), 32'd0);
        rst_n_a = 1'b1; pix_a = 1'b0;

        // ---- dut_b: reset, then three frame starts at one strobe per clock ----
        rst_n_b = 1'b0; pix_b = 1'b1;
        step();
        check("b_rst_x", 32'(x_b), 32'd14);
        check("b_rst_y", 32'(y_b), 32'd10);
        check("b_rst_vs", 32'(vs_b), 32'd0);
`ifdef RASTER_TIMING_FRAME_CNT_EN
        check("b_rst_cnt", 32'(cnt_b), 32'd0);
`endif
        rst_n_b = 1'b1;
        mx = 14; my = 10; err = 0;
        fs_n = 0; t1 = 0; t2 = 0; t3 = 0;
        vs_hi = 0; hs_hi = 0; rises = 0; falls = 0; ymax = 0;
        prev_vs = vs_b;
        for (int s = 1; s <= 331; s++) begin
            if (mx == 14) begin
                mx = 0;
                my = (my == 10) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            step();
            e_de = (mx < 8) && (my < 6);
            e_hs = (mx >= 10) && (mx < 13);
            e_vs = (my >= 7) && (my < 9);
            e_fs = (mx == 0) && (my == 0);
            if (32'(x_b) != mx || 32'(y_b) != my) err++;
            if (de_b !== e_de || hs_b !== e_hs || vs_b !== e_vs || fs_b !== e_fs) err++;
            if (fs_b) begin
                fs_n++;
                if (fs_n == 1) t1 = s;
                if (fs_n == 2) t2 = s;
                if (fs_n == 3) t3 = s;
            end
            if (s <= 165 && vs_b) vs_hi++;
            if (s <= 165 && hs_b) hs_hi++;
            if (!prev_vs && vs_b) rises++;
            if (prev_vs && !vs_b) falls++;
            prev_vs = vs_b;
            if (int'(y_b) > ymax) ymax = int'(y_b);
        end
        check("b_frame_model_errors", 32'(err), 32'd0);
        check("b_frame_start_count", 32'(fs_n), 32'd3);
        check("b_first_frame_start", 32'(t1), 32'd1);
        check("b_frame_period_1", 32'(t2 - t1), 32'd165);
        check("b_frame_period_2", 32'(t3 - t2), 32'd165);
        check("b_vsync_high_strobes", 32'(vs_hi), 32'd30);
        check("b_hsync_high_strobes", 32'(hs_hi), 32'd33);
        check("b_vsync_rises", 32'(rises), 32'd2);
        check("b_vsync_falls", 32'(falls), 32'd2);
        check("b_max_y", 32'(ymax), 32'd10);
`ifdef RASTER_TIMING_FRAME_CNT_EN
        check("b_frame_cnt_3", 32'(cnt_b), 32'd3);
`endif

        // ---- dut_b: strobe every 4th clock, one frame = 660 clocks ----
        fs_n = 0; t1 = -1; t2 = -1; wide = 0; prev_fs = fs_b;
        for (int c = 0; c < 1400; c++) begin
            pix_b = (c % 4 == 0);
            step();
            if (fs_b) begin
                fs_n++;
                if (prev_fs) wide++;
                if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
            end
            prev_fs = fs_b;
        end
        check("b4_frame_starts", 32'(fs_n), 32'd2);
        check("b4_first_start_clk", 32'(t1), 32'd656);
        check("b4_frame_clocks", 32'(t2 - t1), 32'd660);
        check("b4_wide_pulses", 32'(wide), 32'd0);
`ifdef RASTER_TIMING_FRAME_CNT_EN
        check("b4_frame_cnt_5", 32'(cnt_b), 32'd5);
`endif

        // ---- dut_b: reset mid-frame while visible, active-high syncs ----
        check("b_mid_pre_x", 32'(x_b), 32'd5);
        check("b_mid_pre_y", 32'(y_b), 32'd1);
        check("b_mid_pre_de", 32'(de_b), 32'd1);
        rst_n_b = 1'b0; pix_b = 1'b1;
        step();
        check("b_mid_rst_x", 32'(x_b), 32'd14);
        check("b_mid_rst_y", 32'(y_b), 32'd10);
        check("b_mid_rst_de", 32'(de_b), 32'd0);
        check("b_mid_rst_hs", 32'(hs_b), 32'd0);
        check("b_mid_rst_vs", 32'(vs_b), 32'd0);
        check("b_mid_rst_fs", 32'(fs_b), 32'd0);
`ifdef RASTER_TIMING_FRAME_CNT_EN
        check("b_mid_rst_cnt", 32'(cnt_b), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
